// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream -> 16-bit instruction-memory writes.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR, CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR
  } state_t;
`endif

  localparam int unsigned LIMIT = (1 << ADDR_W) - BASE_ADDR;

  state_t            state, state_n;
  logic [15:0]       count, count_n;
  logic [15:0]       index, index_n;
  logic [7:0]        wdata_hi, wdata_hi_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_n;
  logic              we_n, hold_n, done_n, error_n;
  logic              accept;
  logic [15:0]       n_word;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        cks, cks_n;
`endif

  assign accept = in_valid && in_ready;
  assign n_word = {count[15:8], in_data};

`ifdef IMEM_LOADER_CKSUM_EN
  assign in_ready = !rst &&
    (state inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK});
`else
  assign in_ready = !rst &&
    (state inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO});
`endif

  always_comb begin
    state_n    = state;
    count_n    = count;
    index_n    = index;
    wdata_hi_n = wdata_hi;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    hold_n     = cpu_hold;
    done_n     = done;
    error_n    = error;
`ifdef IMEM_LOADER_CKSUM_EN
    cks_n      = cks;
`endif
    unique case (state)
      CNT_HI: if (accept) begin
        count_n[15:8] = in_data;
        state_n       = CNT_LO;
      end
      CNT_LO: if (accept) begin
        count_n[7:0] = in_data;
`ifdef IMEM_LOADER_CKSUM_EN
        cks_n        = 8'h00;
`endif
        // Bounding N here guarantees the address never wraps.
        if (n_word == 16'd0 || 32'(n_word) > LIMIT) begin
          state_n = ERROR;
          error_n = 1'b1;
          hold_n  = 1'b1;
        end else begin
          index_n = 16'd0;
          state_n = DAT_HI;
        end
      end
      DAT_HI: if (accept) begin
        wdata_hi_n = in_data;
`ifdef IMEM_LOADER_CKSUM_EN
        cks_n      = cks ^ in_data;
`endif
        state_n    = DAT_LO;
      end
      DAT_LO: if (accept) begin
        wdata_n = {wdata_hi, in_data};
        addr_n  = ADDR_W'(BASE_ADDR) + ADDR_W'(index);
`ifdef IMEM_LOADER_CKSUM_EN
        cks_n   = cks ^ in_data;
`endif
        state_n = WRITE;
      end
      WRITE: begin
        index_n = index + 16'd1;
        if (index + 16'd1 == count) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
          done_n  = 1'b1;
          hold_n  = 1'b0;
`endif
        end else begin
          state_n = DAT_HI;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CHK: if (accept) begin
        if (in_data == cks) begin
          state_n = DONE;
          done_n  = 1'b1;
          hold_n  = 1'b0;
        end else begin
          state_n = ERROR;
          error_n = 1'b1;
          hold_n  = 1'b1;
        end
      end
`endif
      DONE: if (reload) begin
        state_n = CNT_HI;
        done_n  = 1'b0;
        hold_n  = 1'b1;
      end
      ERROR: if (reload) begin
        state_n = CNT_HI;
        error_n = 1'b0;
      end
      default: state_n = CNT_HI;
    endcase
    we_n = (state_n == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CNT_HI;
      count     <= 16'd0;
      index     <= 16'd0;
      wdata_hi  <= 8'h00;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_we    <= 1'b0;
      mem_wdata <= 16'h0000;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks       <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      count     <= count_n;
      index     <= index_n;
      wdata_hi  <= wdata_hi_n;
      mem_addr  <= addr_n;
      mem_we    <= we_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      done      <= done_n;
      error     <= error_n;
`ifdef IMEM_LOADER_CKSUM_EN
      cks       <= cks_n;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
// Also covers the checksum path when IMEM_LOADER_CKSUM_EN is defined.
module tb_imem_boot_loader;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  imem_boot_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [AW+15:0] obs_q[$];
  logic [AW+15:0] exp_q[$];
  logic [7:0] xsum;

  always @(negedge clk)
    if (mem_we) obs_q.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int tmo;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = b;
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      step();
      tmo++;
    end
    chk("ready_wait", 32'(tmo < 50), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic begin_image(input logic [15:0] n, input int gap);
    xsum = 8'h00;
    send(n[15:8], gap);
    send(n[7:0], gap);
  endtask

  task automatic word(input logic [AW-1:0] a, input logic [15:0] w,
                      input int gap);
    send(w[15:8], gap);
    exp_q.push_back({a, w});
    send(w[7:0], gap);
    xsum = xsum ^ w[15:8] ^ w[7:0];
  endtask

  task automatic end_image();
`ifdef IMEM_LOADER_CKSUM_EN
    send(xsum, 0);
`endif
  endtask

  task automatic wait_end(input string tag);
    int tmo;
    tmo = 0;
    while (!(done || error) && tmo < 20) begin
      step();
      tmo++;
    end
    chk({tag, "_end_wait"}, 32'(tmo < 20), 32'd1);
  endtask

  task automatic scoreboard(input string tag);
    logic [AW+15:0] o, e;
    chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_write"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    reload = 1'b0;
    repeat (3) step();
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(in_ready), 32'd1);

    // Back-to-back 3-word image
    begin_image(16'd3, 0);
    word(9'd0, 16'h1234, 0);
    word(9'd1, 16'hABCD, 0);
    word(9'd2, 16'h0001, 0);
    chk("last_we_lat", 32'(mem_we), 32'd1);
    end_image();
    step();
    step();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_hold", 32'(cpu_hold), 32'd0);
    chk("b2b_ready", 32'(in_ready), 32'd0);
    chk("b2b_error", 32'(error), 32'd0);
    chk("b2b_we_idle", 32'(mem_we), 32'd0);
    scoreboard("b2b");

    // Reload from DONE, with an ignored reload in DAT_HI
    pulse_reload();
    chk("rl_hold", 32'(cpu_hold), 32'd1);
    chk("rl_done", 32'(done), 32'd0);
    begin_image(16'd1, 0);
    pulse_reload();
    chk("rl_dathi_ready", 32'(in_ready), 32'd1);
    chk("rl_dathi_hold", 32'(cpu_hold), 32'd1);
    word(9'd0, 16'h55AA, 0);
    end_image();
    wait_end("rl");
    chk("rl_done2", 32'(done), 32'd1);
    chk("rl_hold2", 32'(cpu_hold), 32'd0);
    scoreboard("rl");

    // Zero count
    pulse_reload();
    begin_image(16'd0, 0);
    chk("zero_error", 32'(error), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd1);
    chk("zero_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    scoreboard("zero");

    // Count 513 exceeds 512-word memory
    pulse_reload();
    chk("err_clear", 32'(error), 32'd0);
    begin_image(16'd513, 0);
    chk("big_error", 32'(error), 32'd1);
    chk("big_hold", 32'(cpu_hold), 32'd1);

    // Count 512 is exactly legal
    pulse_reload();
    begin_image(16'd512, 0);
    chk("max_error", 32'(error), 32'd0);
    chk("max_ready", 32'(in_ready), 32'd1);

    // Reset after the first of three words
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    begin_image(16'd3, 0);
    word(9'd0, 16'h1234, 0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    begin_image(16'd1, 0);
    word(9'd0, 16'hBEEF, 0);
    end_image();
    wait_end("beef");
    chk("beef_done", 32'(done), 32'd1);
    scoreboard("beef");

    // Same 3-word image with random in_valid gaps
    pulse_reload();
    begin_image(16'd3, $urandom_range(5, 0));
    word(9'd0, 16'h1234, $urandom_range(5, 0));
    word(9'd1, 16'hABCD, $urandom_range(5, 0));
    word(9'd2, 16'h0001, $urandom_range(5, 0));
    end_image();
    wait_end("gap");
    chk("gap_done", 32'(done), 32'd1);
    repeat (4) step();
    scoreboard("gap");

`ifdef IMEM_LOADER_CKSUM_EN
    pulse_reload();
    begin_image(16'd1, 0);
    word(9'd0, 16'h1234, 0);
    send(8'h26, 0);
    chk("ck_ok_done", 32'(done), 32'd1);
    chk("ck_ok_error", 32'(error), 32'd0);
    scoreboard("ck_ok");
    pulse_reload();
    begin_image(16'd1, 0);
    word(9'd0, 16'h1234, 0);
    send(8'h27, 0);
    chk("ck_bad_error", 32'(error), 32'd1);
    chk("ck_bad_hold", 32'(cpu_hold), 32'd1);
    chk("ck_bad_done", 32'(done), 32'd0);
    scoreboard("ck_bad");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
